// File: rtl/periph_pkg.sv
// ----------------------------------------------------------------------------
// periph_pkg
// Shared constants for the debug/termination peripheral and its write buffer.
//   DEBUG_BASE_ADDR : byte address of the peripheral register
//   PASS_CODE       : word the termination peripheral treats as "test passed"
//   is_hit()        : core-side store decode against a base address
// ----------------------------------------------------------------------------
package periph_pkg;

    localparam logic [31:0] DEBUG_BASE_ADDR = 32'h0000_8010;
    localparam logic [31:0] PASS_CODE       = 32'h0000_0001;

    // A store hits the peripheral only when both strobes are low and the
    // full byte address matches; reads and other addresses are ignored.
    function automatic logic is_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic        csb,
                                    input logic        wen);
        return (!csb && !wen && (addr == base));
    endfunction

endpackage

// File: rtl/periph_write_buffer_if.sv
// ----------------------------------------------------------------------------
// periph_write_buffer_if
// Bundles the core data-memory port and the peripheral strobe port of the
// posted-write buffer.
//   core side : addr_i, data_i, csb_i, wen_i (in), stall_o (out)
//   periph    : periph_data_o, periph_csb_o, periph_wen_o (out),
//               periph_ready_i (in)
//   status    : count_o (out), occupancy of the buffer
// slave modport is taken by the buffer, master by whoever drives it.
// ----------------------------------------------------------------------------
interface periph_write_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   addr_i;
    logic [31:0]   data_i;
    logic          csb_i;
    logic          wen_i;
    logic          stall_o;
    logic [31:0]   periph_data_o;
    logic          periph_csb_o;
    logic          periph_wen_o;
    logic          periph_ready_i;
    logic [CW-1:0] count_o;

    modport slave (
        input  addr_i, data_i, csb_i, wen_i, periph_ready_i,
        output stall_o, periph_data_o, periph_csb_o, periph_wen_o, count_o
    );

    modport master (
        output addr_i, data_i, csb_i, wen_i, periph_ready_i,
        input  stall_o, periph_data_o, periph_csb_o, periph_wen_o, count_o
    );

endinterface

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy counter. Push on a full FIFO and pop on an
// empty FIFO are ignored. Full/empty derive from the counter.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   push_i, data_i : write data_i at the tail
//   pop_i          : advance the head
//   full_o/empty_o : occupancy == DEPTH / == 0
//   count_o        : occupancy
//   head_o         : entry at the head (undefined content when empty)
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        full_o    = (count_q == CW'(DEPTH));
        empty_o   = (count_q == CW'(0));
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;

        if (do_push_s) begin
            mem_d[wr_ptr_q] = data_i;
            // DEPTH is a power of two, so natural overflow wraps the pointer
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every pending entry
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/periph_write_buffer.sv
// ----------------------------------------------------------------------------
// periph_write_buffer
// Posted-write buffer between the core data-memory port and the debug /
// termination peripheral. Stores to BASE_ADDR are queued; the queue drains
// one word per accepted strobe. The core only stalls when the queue is full.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   bus (slave)    : core port (addr/data/csb/wen in, stall out), peripheral
//                    strobe port (data/csb/wen out, ready in), count_o
// stall_o depends on the decode and registered occupancy only, never on
// periph_ready_i, so a space freed by a pop is usable one cycle later.
// ----------------------------------------------------------------------------
module periph_write_buffer
    import periph_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = DEBUG_BASE_ADDR
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    periph_write_buffer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          hit_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic [31:0]   head_s;

    // Address decode, stall and strobe mapping
    always_comb begin
        hit_s  = is_hit(bus.addr_i, BASE_ADDR, bus.csb_i, bus.wen_i);
        push_s = hit_s && !full_s;
        pop_s  = !empty_s && bus.periph_ready_i;

        bus.stall_o      = hit_s && full_s;
        bus.periph_csb_o = empty_s;
        bus.periph_wen_o = empty_s;
        bus.count_o      = count_s;

        // Present zero instead of stale storage when nothing is pending
        if (empty_s) begin
            bus.periph_data_o = 32'h0000_0000;
        end else begin
            bus.periph_data_o = head_s;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (bus.data_i),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s),
        .head_o  (head_s)
    );

endmodule
